bpfvm_pktbuf_owner: RTL and testbench

// Ownership controller for the two packet buffers (0/1) shared by snooper, BPF CPU and forwarder.

---
 rtl/bpfvm_pktbuf_owner.sv | 192 +++++++++++++++++++
 tb/tb_bpfvm_pktbuf_owner.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bpfvm_pktbuf_owner.sv
// ----------------------------------------------------------------------------
// bpfvm_pktbuf_owner
//
// Ownership controller for the two packet buffers shared by the snooper, the
// BPF CPU and the forwarder. Each buffer carries its own small state machine
// (EMPTY -> SNOOP -> READY -> CPU -> FWD/EMPTY). Filled buffers are handed to
// the CPU in arrival order. Each buffer's packet length is latched when the
// snooper finishes it. Accept/reject verdicts are counted with saturating
// counters.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   snoop_rdy/snoop_sel   snooper owns buffer snoop_sel
//   snoop_done/snoop_len  snooper finished its buffer; packet length
//   mem_ready/cpu_sel     CPU owns buffer cpu_sel
//   cpu_len               length of the CPU-owned buffer
//   accept/reject         verdict pulses from the CPU controller
//   fwd_rdy/fwd_sel       forwarder owns buffer fwd_sel
//   fwd_len               length of the forwarder-owned buffer
//   fwd_done              forwarder finished its buffer
//   accept_cnt/reject_cnt saturating verdict counters
//
// All outputs decode registered state only. No input reaches an output
// combinationally.
// ----------------------------------------------------------------------------
module bpfvm_pktbuf_owner #(
    parameter int LEN_WIDTH  = 11,
    parameter bit FWD_ENABLE = 1'b1,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 snoop_rdy,
    output logic                 snoop_sel,
    input  logic                 snoop_done,
    input  logic [LEN_WIDTH-1:0] snoop_len,
    output logic                 mem_ready,
    output logic                 cpu_sel,
    output logic [LEN_WIDTH-1:0] cpu_len,
    input  logic                 accept,
    input  logic                 reject,
    output logic                 fwd_rdy,
    output logic                 fwd_sel,
    output logic [LEN_WIDTH-1:0] fwd_len,
    input  logic                 fwd_done,
    output logic [CNT_WIDTH-1:0] accept_cnt,
    output logic [CNT_WIDTH-1:0] reject_cnt
);

    typedef enum logic [2:0] {
        ST_EMPTY,
        ST_SNOOP,
        ST_READY,
        ST_CPU,
        ST_FWD
    } buf_state_t;

    buf_state_t           state     [2];
    buf_state_t           state_nxt [2];
    logic [LEN_WIDTH-1:0] len_q     [2];
    logic [LEN_WIDTH-1:0] len_nxt   [2];
    logic                 newest;
    logic                 newest_nxt;
    logic [CNT_WIDTH-1:0] acc_q;
    logic [CNT_WIDTH-1:0] rej_q;

    logic [1:0] in_empty;
    logic [1:0] in_snoop;
    logic [1:0] in_ready;
    logic [1:0] in_cpu;
    logic [1:0] in_fwd;

    logic snoop_any, snoop_idx;
    logic cpu_any, cpu_idx;
    logic fwd_any, fwd_idx;
    logic claim_ok, claim_idx;
    logic grant_ok, grant_idx;
    logic verdict_valid;

    // Per-buffer state decode. At most one buffer is in each role, so the
    // owning buffer's index is simply the bit for buffer 1.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            in_empty[i] = (state[i] == ST_EMPTY);
            in_snoop[i] = (state[i] == ST_SNOOP);
            in_ready[i] = (state[i] == ST_READY);
            in_cpu[i]   = (state[i] == ST_CPU);
            in_fwd[i]   = (state[i] == ST_FWD);
        end
    end

    assign snoop_any = |in_snoop;
    assign snoop_idx = in_snoop[1];
    assign cpu_any   = |in_cpu;
    assign cpu_idx   = in_cpu[1];
    assign fwd_any   = |in_fwd;
    assign fwd_idx   = in_fwd[1];

    // Only buffers that are EMPTY before this edge can be claimed. A buffer
    // freed at this edge is therefore never re-granted in the same edge.
    assign claim_ok  = !snoop_any && (|in_empty);
    assign claim_idx = !in_empty[0];

    // When both buffers wait, the older one (not the newest) goes first.
    assign grant_ok  = !cpu_any && (|in_ready);
    assign grant_idx = (in_ready == 2'b11) ? ~newest : in_ready[1];

    // Verdicts only count while the CPU actually owns a buffer.
    assign verdict_valid = cpu_any && (accept || reject);

    // Next-state logic. Every buffer is in exactly one state, so each rule
    // below touches a different buffer and all of them can apply in one edge.
    always_comb begin
        state_nxt[0] = state[0];
        state_nxt[1] = state[1];
        len_nxt[0]   = len_q[0];
        len_nxt[1]   = len_q[1];
        newest_nxt   = newest;

        if (fwd_any && fwd_done) begin
            state_nxt[fwd_idx] = ST_EMPTY;
        end

        // Reject wins over a simultaneous accept.
        if (verdict_valid) begin
            if (!reject && FWD_ENABLE) begin
                state_nxt[cpu_idx] = ST_FWD;
            end else begin
                state_nxt[cpu_idx] = ST_EMPTY;
            end
        end

        if (grant_ok) begin
            state_nxt[grant_idx] = ST_CPU;
        end

        if (snoop_any && snoop_done) begin
            state_nxt[snoop_idx] = ST_READY;
            len_nxt[snoop_idx]   = snoop_len;
            newest_nxt           = snoop_idx;
        end

        if (claim_ok) begin
            state_nxt[claim_idx] = ST_SNOOP;
        end
    end

    // State, length and counter registers. The counters stick at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state[0] <= ST_EMPTY;
            state[1] <= ST_EMPTY;
            len_q[0] <= '0;
            len_q[1] <= '0;
            newest   <= 1'b0;
            acc_q    <= '0;
            rej_q    <= '0;
        end else begin
            state[0] <= state_nxt[0];
            state[1] <= state_nxt[1];
            len_q[0] <= len_nxt[0];
            len_q[1] <= len_nxt[1];
            newest   <= newest_nxt;
            if (verdict_valid) begin
                if (reject) begin
                    if (rej_q != '1) begin
                        rej_q <= rej_q + CNT_WIDTH'(1);
                    end
                end else if (acc_q != '1) begin
                    acc_q <= acc_q + CNT_WIDTH'(1);
                end
            end
        end
    end

    assign snoop_rdy  = snoop_any;
    assign snoop_sel  = in_snoop[1];
    assign mem_ready  = cpu_any;
    assign cpu_sel    = in_cpu[1];
    assign cpu_len    = cpu_any ? len_q[cpu_idx] : '0;
    assign fwd_rdy    = fwd_any;
    assign fwd_sel    = in_fwd[1];
    assign fwd_len    = fwd_any ? len_q[fwd_idx] : '0;
    assign accept_cnt = acc_q;
    assign reject_cnt = rej_q;

    // The forwarder must release its buffer before the CPU controller
    // accepts another packet. Otherwise both buffers would end up in FWD.
    a_single_fwd : assert property (@(posedge clk) disable iff (!rst_n)
        in_fwd != 2'b11);

endmodule

// File: tb/tb_bpfvm_pktbuf_owner.sv
// ----------------------------------------------------------------------------
// tb_bpfvm_pktbuf_owner
//
// Directed scenarios on a forwarding instance, followed by randomized traffic
// on a forwarding and a non-forwarding instance. The random traffic is
// checked against an owner/queue model of the buffer hand-off rules.
// Both instances use 4-bit counters, so counter saturation is reachable.
// ----------------------------------------------------------------------------
module tb_bpfvm_pktbuf_owner;

    localparam int LW = 11;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          snoop_done = 1'b0;
    logic [LW-1:0] snoop_len = '0;
    logic          accept = 1'b0;
    logic          reject = 1'b0;
    logic          fwd_done = 1'b0;

    logic          a_snoop_rdy, a_snoop_sel, a_mem_ready, a_cpu_sel, a_fwd_rdy, a_fwd_sel;
    logic [LW-1:0] a_cpu_len, a_fwd_len;
    logic [CW-1:0] a_accept_cnt, a_reject_cnt;
    logic          b_snoop_rdy, b_snoop_sel, b_mem_ready, b_cpu_sel, b_fwd_rdy, b_fwd_sel;
    logic [LW-1:0] b_cpu_len, b_fwd_len;
    logic [CW-1:0] b_accept_cnt, b_reject_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state, one set per instance (0: forwarding, 1: not).
    int snoop_o [2];
    int cpu_o   [2];
    int fwd_o   [2];
    int rq      [2][$];
    int mlen    [2][2];
    int macc    [2];
    int mrej    [2];

    bpfvm_pktbuf_owner #(.LEN_WIDTH(LW), .FWD_ENABLE(1'b1), .CNT_WIDTH(CW)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .snoop_rdy(a_snoop_rdy), .snoop_sel(a_snoop_sel),
        .snoop_done(snoop_done), .snoop_len(snoop_len),
        .mem_ready(a_mem_ready), .cpu_sel(a_cpu_sel), .cpu_len(a_cpu_len),
        .accept(accept), .reject(reject),
        .fwd_rdy(a_fwd_rdy), .fwd_sel(a_fwd_sel), .fwd_len(a_fwd_len),
        .fwd_done(fwd_done),
        .accept_cnt(a_accept_cnt), .reject_cnt(a_reject_cnt)
    );

    bpfvm_pktbuf_owner #(.LEN_WIDTH(LW), .FWD_ENABLE(1'b0), .CNT_WIDTH(CW)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .snoop_rdy(b_snoop_rdy), .snoop_sel(b_snoop_sel),
        .snoop_done(snoop_done), .snoop_len(snoop_len),
        .mem_ready(b_mem_ready), .cpu_sel(b_cpu_sel), .cpu_len(b_cpu_len),
        .accept(accept), .reject(reject),
        .fwd_rdy(b_fwd_rdy), .fwd_sel(b_fwd_sel), .fwd_len(b_fwd_len),
        .fwd_done(fwd_done),
        .accept_cnt(b_accept_cnt), .reject_cnt(b_reject_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [35:0] exp_vec(input bit sr, input bit ss, input bit mr, input bit cs,
                                            input int cl, input bit fr, input bit fs, input int fl,
                                            input int ac, input int rc);
        return {sr, ss, mr, cs, LW'(cl), fr, fs, LW'(fl), CW'(ac), CW'(rc)};
    endfunction

    function automatic logic [35:0] a_vec();
        return {a_snoop_rdy, a_snoop_sel, a_mem_ready, a_cpu_sel, a_cpu_len,
                a_fwd_rdy, a_fwd_sel, a_fwd_len, a_accept_cnt, a_reject_cnt};
    endfunction

    function automatic logic [35:0] b_vec();
        return {b_snoop_rdy, b_snoop_sel, b_mem_ready, b_cpu_sel, b_cpu_len,
                b_fwd_rdy, b_fwd_sel, b_fwd_len, b_accept_cnt, b_reject_cnt};
    endfunction

    // ------------------------------------------------------------------
    // Reference model: explicit owners plus an arrival-ordered ready queue
    // ------------------------------------------------------------------
    task automatic model_reset(input int m);
        snoop_o[m] = -1;
        cpu_o[m]   = -1;
        fwd_o[m]   = -1;
        rq[m].delete();
        mlen[m][0] = 0;
        mlen[m][1] = 0;
        macc[m]    = 0;
        mrej[m]    = 0;
    endtask

    function automatic int lowest_free(input int m);
        for (int b = 0; b < 2; b++) begin
            bit queued = 1'b0;
            foreach (rq[m][k]) if (rq[m][k] == b) queued = 1'b1;
            if (snoop_o[m] != b && cpu_o[m] != b && fwd_o[m] != b && !queued) return b;
        end
        return -1;
    endfunction

    // Predicts the effect of the next rising edge from the current inputs.
    task automatic model_step(input int m, input bit fwd_en);
        int s = snoop_o[m];
        int c = cpu_o[m];
        int f = fwd_o[m];
        int fr = lowest_free(m);
        if (f >= 0 && fwd_done) fwd_o[m] = -1;
        if (c >= 0 && (accept || reject)) begin
            cpu_o[m] = -1;
            if (reject) begin
                if (mrej[m] < CMAX) mrej[m]++;
            end else begin
                if (macc[m] < CMAX) macc[m]++;
                if (fwd_en) fwd_o[m] = c;
            end
        end
        if (c < 0 && rq[m].size() > 0) cpu_o[m] = rq[m].pop_front();
        if (s >= 0 && snoop_done) begin
            rq[m].push_back(s);
            mlen[m][s] = int'(snoop_len);
            snoop_o[m] = -1;
        end
        if (s < 0 && fr >= 0) snoop_o[m] = fr;
    endtask

    function automatic logic [35:0] model_vec(input int m);
        return exp_vec(snoop_o[m] >= 0, snoop_o[m] == 1, cpu_o[m] >= 0, cpu_o[m] == 1,
                       (cpu_o[m] >= 0) ? mlen[m][cpu_o[m] & 1] : 0,
                       fwd_o[m] >= 0, fwd_o[m] == 1,
                       (fwd_o[m] >= 0) ? mlen[m][fwd_o[m] & 1] : 0,
                       macc[m], mrej[m]);
    endfunction

    // ------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (a_vec() !== exp_vec(0,0,0,0,0,0,0,0,0,0)) begin
            errors++;
            $display("[TB] FAIL reset_hold: got %h want %h", a_vec(), exp_vec(0,0,0,0,0,0,0,0,0,0));
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (a_vec() !== exp_vec(1,0,0,0,0,0,0,0,0,0)) begin
            errors++;
            $display("[TB] FAIL reset_release: got %h want %h", a_vec(), exp_vec(1,0,0,0,0,0,0,0,0,0));
        end
    endtask

    task automatic test_snoop_to_cpu();
        snoop_done = 1'b1; snoop_len = LW'(64);
        tick();
        snoop_done = 1'b0;
        checks++;
        if (a_vec() !== exp_vec(0,0,0,0,0,0,0,0,0,0)) begin
            errors++;
            $display("[TB] FAIL snoop_done_ready: got %h want %h", a_vec(), exp_vec(0,0,0,0,0,0,0,0,0,0));
        end
        tick();
        checks++;
        if (a_vec() !== exp_vec(1,1,1,0,64,0,0,0,0,0)) begin
            errors++;
            $display("[TB] FAIL cpu_grant: got %h want %h", a_vec(), exp_vec(1,1,1,0,64,0,0,0,0,0));
        end
    endtask

    task automatic test_order();
        snoop_done = 1'b1; snoop_len = LW'(100);
        tick();
        snoop_done = 1'b0;
        checks++;
        if (a_vec() !== exp_vec(0,0,1,0,64,0,0,0,0,0)) begin
            errors++;
            $display("[TB] FAIL second_fill: got %h want %h", a_vec(), exp_vec(0,0,1,0,64,0,0,0,0,0));
        end
        reject = 1'b1;
        tick();
        reject = 1'b0;
        checks++;
        if (a_vec() !== exp_vec(0,0,0,0,0,0,0,0,0,1)) begin
            errors++;
            $display("[TB] FAIL reject_gap: got %h want %h", a_vec(), exp_vec(0,0,0,0,0,0,0,0,0,1));
        end
        tick();
        checks++;
        if (a_vec() !== exp_vec(1,0,1,1,100,0,0,0,0,1)) begin
            errors++;
            $display("[TB] FAIL cpu_grant_waiting: got %h want %h", a_vec(), exp_vec(1,0,1,1,100,0,0,0,0,1));
        end
        snoop_done = 1'b1; snoop_len = LW'(200);
        tick();
        snoop_done = 1'b0;
        reject = 1'b1;
        tick();
        reject = 1'b0;
        checks++;
        if (a_vec() !== exp_vec(0,0,0,0,0,0,0,0,0,2)) begin
            errors++;
            $display("[TB] FAIL reject_gap2: got %h want %h", a_vec(), exp_vec(0,0,0,0,0,0,0,0,0,2));
        end
        tick();
        checks++;
        if (a_vec() !== exp_vec(1,1,1,0,200,0,0,0,0,2)) begin
            errors++;
            $display("[TB] FAIL cpu_grant_order: got %h want %h", a_vec(), exp_vec(1,1,1,0,200,0,0,0,0,2));
        end
    endtask

    task automatic test_forward();
        accept = 1'b1; snoop_done = 1'b1; snoop_len = LW'(300);
        tick();
        accept = 1'b0; snoop_done = 1'b0;
        checks++;
        if (a_vec() !== exp_vec(0,0,0,0,0,1,0,200,1,2)) begin
            errors++;
            $display("[TB] FAIL accept_to_fwd: got %h want %h", a_vec(), exp_vec(0,0,0,0,0,1,0,200,1,2));
        end
        tick();
        checks++;
        if (a_vec() !== exp_vec(0,0,1,1,300,1,0,200,1,2)) begin
            errors++;
            $display("[TB] FAIL cpu_while_fwd: got %h want %h", a_vec(), exp_vec(0,0,1,1,300,1,0,200,1,2));
        end
        fwd_done = 1'b1;
        tick();
        fwd_done = 1'b0;
        checks++;
        if (a_vec() !== exp_vec(0,0,1,1,300,0,0,0,1,2)) begin
            errors++;
            $display("[TB] FAIL fwd_done_free: got %h want %h", a_vec(), exp_vec(0,0,1,1,300,0,0,0,1,2));
        end
        tick();
        checks++;
        if (a_vec() !== exp_vec(1,0,1,1,300,0,0,0,1,2)) begin
            errors++;
            $display("[TB] FAIL regrant_snoop: got %h want %h", a_vec(), exp_vec(1,0,1,1,300,0,0,0,1,2));
        end
    endtask

    task automatic test_both_verdicts();
        accept = 1'b1; reject = 1'b1;
        tick();
        accept = 1'b0; reject = 1'b0;
        checks++;
        if (a_vec() !== exp_vec(1,0,0,0,0,0,0,0,1,3)) begin
            errors++;
            $display("[TB] FAIL accept_reject: got %h want %h", a_vec(), exp_vec(1,0,0,0,0,0,0,0,1,3));
        end
        accept = 1'b1; fwd_done = 1'b1;
        tick();
        accept = 1'b0; fwd_done = 1'b0;
        checks++;
        if (a_vec() !== exp_vec(1,0,0,0,0,0,0,0,1,3)) begin
            errors++;
            $display("[TB] FAIL stray_verdict: got %h want %h", a_vec(), exp_vec(1,0,0,0,0,0,0,0,1,3));
        end
    endtask

    task automatic test_saturation();
        int exp_acc = 1;
        int exp_rej = 3;
        for (int i = 0; i < 32; i++) begin
            int n = 0;
            while (a_snoop_rdy !== 1'b1 && n < 8) begin tick(); n++; end
            checks++;
            if (a_snoop_rdy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL sat_wait_snoop: got %b want 1", a_snoop_rdy);
            end
            snoop_done = 1'b1; snoop_len = LW'(i);
            tick();
            snoop_done = 1'b0;
            n = 0;
            while (a_mem_ready !== 1'b1 && n < 8) begin tick(); n++; end
            checks++;
            if (a_mem_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL sat_wait_cpu: got %b want 1", a_mem_ready);
            end
            if (i % 2 == 0) begin
                accept = 1'b1;
                if (exp_acc < CMAX) exp_acc++;
            end else begin
                reject = 1'b1;
                if (exp_rej < CMAX) exp_rej++;
            end
            tick();
            accept = 1'b0; reject = 1'b0;
            checks++;
            if ({a_accept_cnt, a_reject_cnt} !== {CW'(exp_acc), CW'(exp_rej)}) begin
                errors++;
                $display("[TB] FAIL sat_counters: got %0d/%0d want %0d/%0d",
                         a_accept_cnt, a_reject_cnt, exp_acc, exp_rej);
            end
            if (i % 2 == 0) begin
                fwd_done = 1'b1;
                tick();
                fwd_done = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        snoop_done = 1'b1; snoop_len = LW'(10);
        tick();
        snoop_done = 1'b0;
        tick();
        snoop_done = 1'b1; snoop_len = LW'(20);
        tick();
        snoop_done = 1'b0;
        reject = 1'b1;
        tick();
        reject = 1'b0;
        tick();
        checks++;
        if (a_vec() !== exp_vec(1,0,1,1,20,0,0,0,0,1)) begin
            errors++;
            $display("[TB] FAIL mid_setup: got %h want %h", a_vec(), exp_vec(1,0,1,1,20,0,0,0,0,1));
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if (a_vec() !== exp_vec(0,0,0,0,0,0,0,0,0,0)) begin
            errors++;
            $display("[TB] FAIL mid_reset: got %h want %h", a_vec(), exp_vec(0,0,0,0,0,0,0,0,0,0));
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (a_vec() !== exp_vec(1,0,0,0,0,0,0,0,0,0)) begin
            errors++;
            $display("[TB] FAIL mid_release: got %h want %h", a_vec(), exp_vec(1,0,0,0,0,0,0,0,0,0));
        end
    endtask

    // ------------------------------------------------------------------
    // Random traffic on both instances against the model
    // ------------------------------------------------------------------
    task automatic test_random();
        rst_n = 1'b0;
        snoop_done = 1'b0; accept = 1'b0; reject = 1'b0; fwd_done = 1'b0;
        model_reset(0);
        model_reset(1);
        tick();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            checks++;
            if (a_vec() !== model_vec(0)) begin
                errors++;
                $display("[TB] FAIL rand_fwd cyc %0d: got %h want %h", cyc, a_vec(), model_vec(0));
            end
            checks++;
            if (b_vec() !== model_vec(1)) begin
                errors++;
                $display("[TB] FAIL rand_nofwd cyc %0d: got %h want %h", cyc, b_vec(), model_vec(1));
            end
            rst_n      = ($urandom_range(0, 99) != 0);
            snoop_done = ($urandom_range(0, 2) == 0);
            snoop_len  = LW'($urandom);
            fwd_done   = ($urandom_range(0, 2) == 0);
            reject     = ($urandom_range(0, 4) == 0);
            accept     = ($urandom_range(0, 3) == 0);
            // The forwarder must drain before another accept is issued.
            if (fwd_o[0] >= 0 && !fwd_done) accept = 1'b0;
            if (!rst_n) begin
                model_reset(0);
                model_reset(1);
            end else begin
                model_step(0, 1'b1);
                model_step(1, 1'b0);
            end
            tick();
        end
        snoop_done = 1'b0; accept = 1'b0; reject = 1'b0; fwd_done = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_snoop_to_cpu();
        test_order();
        test_forward();
        test_both_verdicts();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
